rv32_fetch_stage: RTL and testbench

Instruction-fetch stage for the 3-stage RV32 pipeline. It sits directly upstream of decode and consumes nothing from it except the ready signal.
- Owns the PC and drives the synchronous instruction memory.
- Buffers returned instructions in a small FIFO and presents them to decode with a valid/ready handshake.
- Accepts branch/jump redirects from execute and flushes stale instructions.

---
 rtl/rv32_pkg.sv | 22 ++
 rtl/rv32_fetch_stage_fifo.sv | 88 ++++++++
 rtl/rv32_fetch_stage.sv | 113 +++++++++++
 tb/tb_rv32_fetch_stage.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv32_pkg
// Description : Shared constants and types for the RV32 fetch stage.
//               XLEN, the canonical NOP encoding (addi x0,x0,0), the default
//               reset PC and the fetch-buffer entry layout {pc, inst}.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32_pkg;

    localparam int          XLEN             = 32;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // One buffered instruction together with the PC it was fetched from.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

endpackage : rv32_pkg
`default_nettype wire

// File: rtl/rv32_fetch_stage_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Synchronous instruction buffer of DEPTH fetch entries.
//               A synchronous clear has priority over push; pop and push may
//               occur in the same cycle. Reset is asynchronous, active-high.
// Ports       : clk, rst         - clock / async active-high reset
//               i_clear          - empty the buffer at the next edge
//               i_push, i_push_data - write one entry at the tail
//               i_pop            - remove the head entry
//               o_head           - current head entry (valid when o_count!=0)
//               o_count          - number of valid entries, 0..DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import rv32_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_clear,
    input  logic                     i_push,
    input  fetch_entry_t             i_push_data,
    input  logic                     i_pop,
    output fetch_entry_t             o_head,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t    mem_q [DEPTH];
    fetch_entry_t    mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q,  count_d;

    logic            w_push;
    logic            w_pop;

    // Guard against over/underflow; the upstream credit logic should never
    // request either, so these only protect the buffer's own invariants.
    assign w_pop  = i_pop  && (count_q != '0);
    assign w_push = i_push && (count_q != CW'(DEPTH) || w_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push) begin
                mem_d[wr_ptr_q] = i_push_data;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign o_head  = mem_q[rd_ptr_q];
    assign o_count = count_q;

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/rv32_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : rv32_fetch_stage
// Description : Instruction-fetch stage of the 3-stage RV32 pipeline. Owns the
//               word-addressed PC, drives a synchronous instruction memory,
//               buffers responses in a small FIFO and hands them to decode
//               over a valid/ready handshake. Redirects from execute flush
//               the buffer and any in-flight response.
// Ports       : clk, reset        - clock / async active-high reset
//               imem_req/addr     - imem read request and word address
//               imem_rdata        - imem data, valid the cycle after a request
//               if_valid/inst/pc  - head of the instruction buffer to decode
//               id_ready          - decode accepts the head this cycle
//               redirect_valid/pc - PC change request from execute
// Revision    : 1.0 - initial release
// ============================================================================
module rv32_fetch_stage
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 2,
    parameter int          IMEM_AW  = 10
) (
    input  logic                clk,
    input  logic                reset,
    output logic                imem_req,
    output logic [IMEM_AW-1:0]  imem_addr,
    input  logic [XLEN-1:0]     imem_rdata,
    output logic                if_valid,
    output logic [XLEN-1:0]     if_inst,
    output logic [XLEN-1:0]     if_pc,
    input  logic                id_ready,
    input  logic                redirect_valid,
    input  logic [XLEN-1:0]     redirect_pc
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int UW = CW + 1;

    logic [XLEN-1:0] pc_q,          pc_d;
    logic            inflight_q,    inflight_d;
    logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;

    logic [CW-1:0]   w_count;
    fetch_entry_t    w_head;
    fetch_entry_t    w_push_data;
    logic            w_valid;
    logic            w_pop;
    logic            w_push;
    logic            w_issue;
    logic [UW-1:0]   w_used;

    assign w_valid = (w_count != '0);
    assign w_pop   = w_valid && id_ready;

    // Credit check: slots already occupied or promised to an in-flight
    // response, less the one leaving this cycle. Issuing only while this is
    // below DEPTH guarantees a response never lands in a full buffer.
    assign w_used  = UW'(w_count) + UW'(inflight_q) - UW'(w_pop);
    assign w_issue = !redirect_valid && (w_used < UW'(DEPTH));

    // A response arriving during a redirect belongs to the old path.
    assign w_push      = inflight_q && !redirect_valid;
    assign w_push_data = '{pc: inflight_pc_q, inst: imem_rdata};

    always_comb begin
        pc_d          = pc_q;
        inflight_d    = w_issue;
        inflight_pc_d = inflight_pc_q;
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (w_issue) begin
            pc_d          = pc_q + 32'd1;
            inflight_pc_d = pc_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (reset),
        .i_clear     (redirect_valid),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_count)
    );

    // The credit term is non-zero while reset is held, so the request is
    // masked to keep imem idle until reset releases.
    assign imem_req  = w_issue && !reset;
    assign imem_addr = pc_q[IMEM_AW-1:0];

    assign if_valid  = w_valid;
    assign if_inst   = w_valid ? w_head.inst : NOP_INST;
    assign if_pc     = w_valid ? w_head.pc   : '0;

endmodule : rv32_fetch_stage
`default_nettype wire

// File: tb/tb_rv32_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv32_fetch_stage
// Description : Directed, table-driven bench for rv32_fetch_stage. A
//               synchronous imem model returns 0x5A5A0000 | addr. Each table
//               row drives decode/redirect inputs mid-cycle and compares the
//               fetch outputs against hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        id_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        req;
        logic [9:0]  addr;
        logic        valid;
        logic [31:0] pc;
    } vec_t;

    vec_t vecs[$];
    vec_t restart[$];

    rv32_fetch_stage #(
        .RESET_PC (32'h0),
        .DEPTH    (2),
        .IMEM_AW  (10)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_inst        (if_inst),
        .if_pc          (if_pc),
        .id_ready       (id_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous instruction memory: data follows the request by one cycle.
    initial imem_rdata = 32'h0;
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= 32'h5A5A_0000 | {22'b0, imem_addr};
    end

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return 32'h5A5A_0000 | {22'b0, pc[9:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void add(ref vec_t q[$], input logic rdy, input logic rv,
                                input logic [31:0] rpc, input logic req,
                                input logic [9:0] addr, input logic valid,
                                input logic [31:0] pc);
        vec_t v;
        v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.req = req;
        v.addr = addr; v.valid = valid; v.pc = pc;
        q.push_back(v);
    endfunction

    // Called just after a falling edge: drive, settle, compare.
    task automatic apply(input vec_t v, input string tag);
        logic [31:0] exp_inst;
        id_ready       = v.rdy;
        redirect_valid = v.rv;
        redirect_pc    = v.rpc;
        #1;
        exp_inst = v.valid ? inst_of(v.pc) : NOP;
        chk({tag, " imem_req"},  {31'b0, imem_req},  {31'b0, v.req});
        chk({tag, " imem_addr"}, {22'b0, imem_addr}, {22'b0, v.addr});
        chk({tag, " if_valid"},  {31'b0, if_valid},  {31'b0, v.valid});
        chk({tag, " if_pc"},     if_pc,              v.valid ? v.pc : 32'h0);
        chk({tag, " if_inst"},   if_inst,            exp_inst);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " imem_req"},  {31'b0, imem_req}, 32'h0);
        chk({tag, " imem_addr"}, {22'b0, imem_addr}, 32'h0);
        chk({tag, " if_valid"},  {31'b0, if_valid}, 32'h0);
        chk({tag, " if_inst"},   if_inst, NOP);
        chk({tag, " if_pc"},     if_pc, 32'h0);
    endtask

    initial begin
        //        rdy rv rpc            req addr    vld pc
        // streaming from reset
        add(vecs, 1, 0, 32'h0,          1, 10'h000, 0, 32'h0);
        add(vecs, 1, 0, 32'h0,          1, 10'h001, 0, 32'h0);
        add(vecs, 1, 0, 32'h0,          1, 10'h002, 1, 32'h0);
        add(vecs, 1, 0, 32'h0,          1, 10'h003, 1, 32'h1);
        add(vecs, 1, 0, 32'h0,          1, 10'h004, 1, 32'h2);
        add(vecs, 1, 0, 32'h0,          1, 10'h005, 1, 32'h3);
        // backpressure for 6 cycles at if_pc=4
        add(vecs, 0, 0, 32'h0,          0, 10'h006, 1, 32'h4);
        for (int i = 0; i < 5; i++)
            add(vecs, 0, 0, 32'h0,      0, 10'h006, 1, 32'h4);
        add(vecs, 1, 0, 32'h0,          1, 10'h006, 1, 32'h4);
        add(vecs, 1, 0, 32'h0,          1, 10'h007, 1, 32'h5);
        add(vecs, 1, 0, 32'h0,          1, 10'h008, 1, 32'h6);
        add(vecs, 1, 0, 32'h0,          1, 10'h009, 1, 32'h7);
        add(vecs, 1, 0, 32'h0,          1, 10'h00A, 1, 32'h8);
        // redirect to 0x40 with an entry buffered and a response in flight
        add(vecs, 0, 1, 32'h40,         0, 10'h00B, 1, 32'h9);
        add(vecs, 1, 0, 32'h0,          1, 10'h040, 0, 32'h0);
        add(vecs, 1, 0, 32'h0,          1, 10'h041, 0, 32'h0);
        add(vecs, 1, 0, 32'h0,          1, 10'h042, 1, 32'h40);
        add(vecs, 1, 0, 32'h0,          1, 10'h043, 1, 32'h41);
        // redirect with simultaneous pop and response
        add(vecs, 1, 1, 32'h100,        0, 10'h044, 1, 32'h42);
        add(vecs, 1, 0, 32'h0,          1, 10'h100, 0, 32'h0);
        add(vecs, 1, 0, 32'h0,          1, 10'h101, 0, 32'h0);
        add(vecs, 1, 0, 32'h0,          1, 10'h102, 1, 32'h100);
        // back-to-back redirects, last target wins
        add(vecs, 1, 1, 32'h10,         0, 10'h103, 1, 32'h101);
        add(vecs, 1, 1, 32'h80,         0, 10'h010, 0, 32'h0);
        add(vecs, 1, 0, 32'h0,          1, 10'h080, 0, 32'h0);
        add(vecs, 1, 0, 32'h0,          1, 10'h081, 0, 32'h0);
        add(vecs, 1, 0, 32'h0,          1, 10'h082, 1, 32'h80);
        add(vecs, 1, 0, 32'h0,          1, 10'h083, 1, 32'h81);
        // PC wrap from 0xFFFFFFFF
        add(vecs, 1, 1, 32'hFFFF_FFFF,  0, 10'h084, 1, 32'h82);
        add(vecs, 1, 0, 32'h0,          1, 10'h3FF, 0, 32'h0);
        add(vecs, 1, 0, 32'h0,          1, 10'h000, 0, 32'h0);
        add(vecs, 1, 0, 32'h0,          1, 10'h001, 1, 32'hFFFF_FFFF);
        add(vecs, 1, 0, 32'h0,          1, 10'h002, 1, 32'h0);
        // restart after an asynchronous reset pulse
        add(restart, 1, 0, 32'h0,       1, 10'h000, 0, 32'h0);
        add(restart, 1, 0, 32'h0,       1, 10'h001, 0, 32'h0);
        add(restart, 1, 0, 32'h0,       1, 10'h002, 1, 32'h0);
        add(restart, 1, 0, 32'h0,       1, 10'h003, 1, 32'h1);

        reset          = 1'b1;
        id_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        @(negedge clk);
        #1;
        chk_reset_state("reset");

        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            if (i != 0) @(negedge clk);
            apply(vecs[i], $sformatf("row%0d", i));
        end

        // Mid-cycle asynchronous reset: outputs must clear before any edge.
        #1;
        reset = 1'b1;
        #1;
        chk_reset_state("async_reset");

        @(negedge clk);
        #1;
        chk_reset_state("reset_held");

        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < restart.size(); i++) begin
            if (i != 0) @(negedge clk);
            apply(restart[i], $sformatf("restart%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_rv32_fetch_stage
`default_nettype wire
